// File: rtl/imem_loader.sv
// Boot loader: fills byte-wide instruction memory from a framed byte stream
// (16-bit length, payload, checksum) and holds the CPU until a verified load.
module imem_loader #(
    parameter int MEM_BYTES = 512,
    parameter int ADDR_W    = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   byte_count
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_e;

    localparam logic [15:0]       MAX_LEN = 16'(MEM_BYTES);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   byte_count_q, byte_count_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        sum_q, sum_d;

    logic        xfer;
    logic [15:0] len_full;
    logic        len_ok;
    logic        last_byte;
    logic [7:0]  sum_next;
    logic        csum_ok;

    assign xfer      = rx_valid & rx_ready;
    assign len_full  = {rx_data, len_lo_q};
    assign len_ok    = (len_full != '0) && (len_full <= MAX_LEN) && (len_full[1:0] == 2'b00);
    assign last_byte = (byte_count_q + CNT_ONE) == len_q;
    assign sum_next  = sum_q + rx_data;
    assign csum_ok   = (sum_next == '0);
    assign byte_count = byte_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo_q     <= '0;
            len_q        <= '0;
            byte_count_q <= '0;
            ptr_q        <= '0;
            sum_q        <= '0;
        end else begin
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            byte_count_q <= byte_count_d;
            ptr_q        <= ptr_d;
            sum_q        <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: if (load_start) state_d = LEN_LO;
            LEN_LO:          if (xfer) state_d = LEN_HI;
            LEN_HI:          if (xfer) state_d = len_ok ? DATA : ERR;
            DATA:            if (xfer && last_byte) state_d = CSUM;
            CSUM:            if (xfer) state_d = csum_ok ? DONE : ERR;
            default:         state_d = IDLE;
        endcase
    end

    always_comb begin
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        byte_count_d = byte_count_q;
        ptr_d        = ptr_q;
        sum_d        = sum_q;
        if (xfer) begin
            case (state_q)
                LEN_LO: len_lo_d = rx_data;
                LEN_HI: begin
                    if (len_ok) begin
                        len_d        = len_full[ADDR_W:0];
                        byte_count_d = '0;
                        ptr_d        = '0;
                        sum_d        = '0;
                    end
                end
                DATA: begin
                    byte_count_d = byte_count_q + CNT_ONE;
                    sum_d        = sum_next;
                    // Pointer stops on the final byte so a full-size image never wraps it.
                    if (!last_byte) ptr_d = ptr_q + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rx_ready  = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CSUM);
        cpu_hold  = (state_q != DONE);
        load_done = (state_q == DONE);
        load_err  = (state_q == ERR);
        mem_we    = (state_q == DATA) && rx_valid;
        mem_waddr = ptr_q;
        mem_wdata = rx_data;
    end

endmodule
